// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game control unit:
// state codes, timeout defaults and the Moore output decode.
package jogo_pkg;

  localparam logic [3:0] COD_INICIAL       = 4'h0;
  localparam logic [3:0] COD_PREPARA       = 4'h1;
  localparam logic [3:0] COD_INICIA_RODADA = 4'h2;
  localparam logic [3:0] COD_ESPERA        = 4'h3;
  localparam logic [3:0] COD_REGISTRA      = 4'h4;
  localparam logic [3:0] COD_COMPARA       = 4'h5;
  localparam logic [3:0] COD_PROX_JOGADA   = 4'h6;
  localparam logic [3:0] COD_PROX_RODADA   = 4'h7;
  localparam logic [3:0] COD_FIM_ACERTO    = 4'hA;
  localparam logic [3:0] COD_FIM_TIMEOUT   = 4'hD;
  localparam logic [3:0] COD_FIM_ERRO      = 4'hE;

  // 5 s per play at a 1 kHz game clock
  localparam int TIMEOUT_CICLOS_PADRAO = 5000;
  localparam int TIMEOUT_W_PADRAO      = 13;

  typedef enum logic [3:0] {
    INICIAL       = COD_INICIAL,
    PREPARA       = COD_PREPARA,
    INICIA_RODADA = COD_INICIA_RODADA,
    ESPERA        = COD_ESPERA,
    REGISTRA      = COD_REGISTRA,
    COMPARA       = COD_COMPARA,
    PROX_JOGADA   = COD_PROX_JOGADA,
    PROX_RODADA   = COD_PROX_RODADA,
    FIM_ACERTO    = COD_FIM_ACERTO,
    FIM_TIMEOUT   = COD_FIM_TIMEOUT,
    FIM_ERRO      = COD_FIM_ERRO
  } estado_t;

  typedef struct packed {
    logic zera_rodada;
    logic conta_rodada;
    logic zera_jogada;
    logic conta_jogada;
    logic registra;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } saidas_t;

  // Moore decode: every datapath enable and status flag is a pure function of the state
  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARA:       begin s.zera_rodada = 1'b1; s.zera_jogada = 1'b1; end
      INICIA_RODADA: s.zera_jogada  = 1'b1;
      REGISTRA:      s.registra     = 1'b1;
      PROX_JOGADA:   s.conta_jogada = 1'b1;
      PROX_RODADA:   s.conta_rodada = 1'b1;
      FIM_ACERTO:    begin s.pronto = 1'b1; s.ganhou = 1'b1; end
      FIM_ERRO:      begin s.pronto = 1'b1; s.perdeu = 1'b1; end
      FIM_TIMEOUT:   begin s.pronto = 1'b1; s.perdeu = 1'b1; s.db_timeout = 1'b1; end
      default:       s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Saturating play-timeout counter: counts up while enabled, holds at M-1,
// cleared synchronously by reset or zera.
module contador_timeout #(
  parameter int M = 5000,
  parameter int N = 13
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic         fim,
  output logic [N-1:0] count
);

  assign fim = (count == N'(M - 1));

  // clear has priority; counting stops at M-1 so the flag never wraps away
  always_ff @(posedge clock) begin
    if (reset || zera)       count <= '0;
    else if (conta && !fim)  count <= count + 1'b1;
  end

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Round-sequencing control unit for the sequence-memory game. Drives the
// datapath clear/count/load enables from its status flags, owns the per-play
// timeout and reports the game result plus a debug state code.
module unidade_controle_rodadas
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int TIMEOUT_W      = TIMEOUT_W_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada_feita,
  input  logic       igual_jogada,
  input  logic       fim_jogada,
  input  logic       fim_rodada,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       zera_jogada,
  output logic       conta_jogada,
  output logic       registra,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t               estado, prox;
  saidas_t               saidas;
  logic                  to_fim;
  logic [TIMEOUT_W-1:0]  to_count;

  // Counter is held at zero outside ESPERA, so every entry starts a fresh window
  contador_timeout #(.M(TIMEOUT_CICLOS), .N(TIMEOUT_W)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (estado != ESPERA),
    .conta (estado == ESPERA),
    .fim   (to_fim),
    .count (to_count)
  );

  // Next-state rules; a button press beats a simultaneous timeout
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:       if (jogar) prox = PREPARA;
      PREPARA:       prox = INICIA_RODADA;
      INICIA_RODADA: prox = ESPERA;
      ESPERA: begin
        if (jogada_feita) prox = REGISTRA;
        else if (to_fim)  prox = FIM_TIMEOUT;
      end
      REGISTRA:      prox = COMPARA;
      COMPARA: begin
        if (!igual_jogada)    prox = FIM_ERRO;
        else if (!fim_jogada) prox = PROX_JOGADA;
        else if (!fim_rodada) prox = PROX_RODADA;
        else                  prox = FIM_ACERTO;
      end
      PROX_JOGADA:   prox = ESPERA;
      PROX_RODADA:   prox = INICIA_RODADA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT:   if (jogar) prox = PREPARA;
      default:       prox = INICIAL;
    endcase
  end

  // State and outputs are registered together so outputs always match db_estado
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      saidas <= '0;
    end else begin
      estado <= prox;
      saidas <= decodifica(prox);
    end
  end

  // The timeout count must saturate, never run past the last legal value
  always_ff @(posedge clock) begin
    if (!reset) assert (int'(to_count) <= TIMEOUT_CICLOS - 1);
  end

  assign zera_rodada  = saidas.zera_rodada;
  assign conta_rodada = saidas.conta_rodada;
  assign zera_jogada  = saidas.zera_jogada;
  assign conta_jogada = saidas.conta_jogada;
  assign registra     = saidas.registra;
  assign pronto       = saidas.pronto;
  assign ganhou       = saidas.ganhou;
  assign perdeu       = saidas.perdeu;
  assign db_timeout   = saidas.db_timeout;
  assign db_estado    = estado;

endmodule
